// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction fetch and IF/ID pipeline register.
// Single-word instructions issue one per cycle. LDM is held in shadow
// registers for one cycle and issues together with its immediate word.
// HLT issues once and then freezes fetch until reset.
module fetch_stage #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               if_id_valid,
    output logic [2:0]         if_id_opcode,
    output logic [2:0]         if_id_rd,
    output logic [2:0]         if_id_rs1,
    output logic [2:0]         if_id_rs2,
    output logic [INSTR_W-1:0] if_id_imm,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        FETCH,
        FETCH_IMM,
        HALT
    } state_t;

    localparam logic [2:0] OP_LDM = 3'b001;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_inc;

    logic [2:0]          sh_rd_q;
    logic [2:0]          sh_rs1_q;
    logic [2:0]          sh_rs2_q;
    logic [ADDR_W-1:0]   sh_pc_q;

    logic                valid_q;
    logic [2:0]          opcode_q;
    logic [2:0]          rd_q;
    logic [2:0]          rs1_q;
    logic [2:0]          rs2_q;
    logic [INSTR_W-1:0]  imm_q;
    logic [ADDR_W-1:0]   ipc_q;
    logic                halted_q;

    logic [2:0]          f_op;
    logic [2:0]          f_rd;
    logic [2:0]          f_rs1;
    logic [2:0]          f_rs2;

    // Instruction word field split; PC increment wraps modulo 2^ADDR_W.
    always_comb begin
        f_op   = imem_data[15:13];
        f_rd   = imem_data[12:10];
        f_rs1  = imem_data[9:7];
        f_rs2  = imem_data[6:4];
        pc_inc = pc_q + ADDR_W'(1);
    end

    // Fetch FSM with PC, shadow and IF/ID registers; stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= ADDR_W'(RESET_PC);
            sh_rd_q  <= '0;
            sh_rs1_q <= '0;
            sh_rs2_q <= '0;
            sh_pc_q  <= '0;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            ipc_q    <= '0;
            halted_q <= 1'b0;
        end else if (!stall) begin
            case (state_q)
                FETCH: begin
                    if (f_op == OP_LDM) begin
                        sh_rd_q  <= f_rd;
                        sh_rs1_q <= f_rs1;
                        sh_rs2_q <= f_rs2;
                        sh_pc_q  <= pc_q;
                        valid_q  <= 1'b0;
                        opcode_q <= '0;
                        rd_q     <= '0;
                        rs1_q    <= '0;
                        rs2_q    <= '0;
                        imm_q    <= '0;
                        ipc_q    <= '0;
                        pc_q     <= pc_inc;
                        state_q  <= FETCH_IMM;
                    end else begin
                        valid_q  <= 1'b1;
                        opcode_q <= f_op;
                        rd_q     <= f_rd;
                        rs1_q    <= f_rs1;
                        rs2_q    <= f_rs2;
                        imm_q    <= '0;
                        ipc_q    <= pc_q;
                        if (f_op == OP_HLT) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            pc_q     <= pc_inc;
                        end
                    end
                end
                FETCH_IMM: begin
                    valid_q  <= 1'b1;
                    opcode_q <= OP_LDM;
                    rd_q     <= sh_rd_q;
                    rs1_q    <= sh_rs1_q;
                    rs2_q    <= sh_rs2_q;
                    imm_q    <= imem_data;
                    ipc_q    <= sh_pc_q;
                    pc_q     <= pc_inc;
                    state_q  <= FETCH;
                end
                HALT: begin
                    valid_q  <= 1'b0;
                    opcode_q <= '0;
                    rd_q     <= '0;
                    rs1_q    <= '0;
                    rs2_q    <= '0;
                    imm_q    <= '0;
                    ipc_q    <= '0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= FETCH;
                end
            endcase
        end
    end

    // Registered outputs; the memory address is the PC itself.
    always_comb begin
        imem_addr    = pc_q;
        if_id_valid  = valid_q;
        if_id_opcode = opcode_q;
        if_id_rd     = rd_q;
        if_id_rs1    = rs1_q;
        if_id_rs2    = rs2_q;
        if_id_imm    = imm_q;
        if_id_pc     = ipc_q;
        halted       = halted_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: straight-line code, LDM, stalls, HLT,
// reset during FETCH_IMM, and PC wrap on a narrow-address instance.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default parameters
    logic        rst_a = 1'b0;
    logic        stall_a = 1'b0;
    logic [7:0]  addr_a;
    logic [15:0] data_a;
    logic        valid_a, halted_a;
    logic [2:0]  op_a, rd_a, rs1_a, rs2_a;
    logic [15:0] imm_a;
    logic [7:0]  ipc_a;
    logic [15:0] mem_a [0:255];
    assign data_a = mem_a[addr_a];

    fetch_stage dut_a (
        .clk(clk), .rst_n(rst_a), .stall(stall_a),
        .imem_addr(addr_a), .imem_data(data_a),
        .if_id_valid(valid_a), .if_id_opcode(op_a), .if_id_rd(rd_a),
        .if_id_rs1(rs1_a), .if_id_rs2(rs2_a), .if_id_imm(imm_a),
        .if_id_pc(ipc_a), .halted(halted_a)
    );

    // Instance B: 4-bit PC starting at the top address
    logic        rst_b = 1'b0;
    logic        stall_b = 1'b0;
    logic [3:0]  addr_b;
    logic [15:0] data_b;
    logic        valid_b, halted_b;
    logic [2:0]  op_b, rd_b, rs1_b, rs2_b;
    logic [15:0] imm_b;
    logic [3:0]  ipc_b;
    logic [15:0] mem_b [0:15];
    assign data_b = mem_b[addr_b];

    fetch_stage #(.ADDR_W(4), .INSTR_W(16), .RESET_PC(15)) dut_b (
        .clk(clk), .rst_n(rst_b), .stall(stall_b),
        .imem_addr(addr_b), .imem_data(data_b),
        .if_id_valid(valid_b), .if_id_opcode(op_b), .if_id_rd(rd_b),
        .if_id_rs1(rs1_b), .if_id_rs2(rs2_b), .if_id_imm(imm_b),
        .if_id_pc(ipc_b), .halted(halted_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the main outputs of instance A in one call.
    task automatic chk_a(input string tag, input logic v, input logic [2:0] op,
                         input logic [2:0] rd, input logic [15:0] imm,
                         input logic [7:0] ipc, input logic [7:0] addr, input logic h);
        chk({tag, ".valid"}, 32'(valid_a), 32'(v));
        chk({tag, ".opcode"}, 32'(op_a), 32'(op));
        chk({tag, ".rd"}, 32'(rd_a), 32'(rd));
        chk({tag, ".imm"}, 32'(imm_a), 32'(imm));
        chk({tag, ".pc"}, 32'(ipc_a), 32'(ipc));
        chk({tag, ".addr"}, 32'(addr_a), 32'(addr));
        chk({tag, ".halted"}, 32'(halted_a), 32'(h));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        #1;
        chk_a("rst", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd0, 1'b0);
        chk("rst.rs1", 32'(rs1_a), 32'd0);
        chk("rst.rs2", 32'(rs2_a), 32'd0);
        step();
        rst_a = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
        for (int i = 0; i < 16; i++) mem_b[i] = 16'h0000;

        // Straight-line code then HLT
        mem_a[0] = 16'h6530;
        mem_a[1] = 16'h9000;
        mem_a[2] = 16'h4000;
        mem_a[3] = 16'hE000;
        #2;
        reset_a();
        step();
        chk_a("add", 1'b1, 3'b011, 3'd1, 16'h0, 8'd0, 8'd1, 1'b0);
        chk("add.rs1", 32'(rs1_a), 32'd2);
        chk("add.rs2", 32'(rs2_a), 32'd3);
        step();
        chk_a("not", 1'b1, 3'b100, 3'd4, 16'h0, 8'd1, 8'd2, 1'b0);
        step();
        chk_a("std", 1'b1, 3'b010, 3'd0, 16'h0, 8'd2, 8'd3, 1'b0);
        step();
        chk_a("hlt", 1'b1, 3'b111, 3'd0, 16'h0, 8'd3, 8'd3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_a("halt_bubble", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd3, 1'b1);
        end

        // LDM sequence with stalls in FETCH and in FETCH_IMM
        mem_a[0] = 16'h2400;
        mem_a[1] = 16'hBEEF;
        mem_a[2] = 16'h6530;
        mem_a[3] = 16'h2800;
        mem_a[4] = 16'h1234;
        mem_a[5] = 16'h9000;
        mem_a[6] = 16'hE000;
        reset_a();
        step();
        chk_a("ldm_bubble", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd1, 1'b0);
        step();
        chk_a("ldm", 1'b1, 3'b001, 3'd1, 16'hBEEF, 8'd0, 8'd2, 1'b0);
        step();
        chk_a("ldm_add", 1'b1, 3'b011, 3'd1, 16'h0, 8'd2, 8'd3, 1'b0);
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("stall_fetch", 1'b1, 3'b011, 3'd1, 16'h0, 8'd2, 8'd3, 1'b0);
        end
        stall_a = 1'b0;
        step();
        chk_a("ldm2_bubble", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd4, 1'b0);
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("stall_imm", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd4, 1'b0);
        end
        stall_a = 1'b0;
        step();
        chk_a("ldm2", 1'b1, 3'b001, 3'd2, 16'h1234, 8'd3, 8'd5, 1'b0);
        step();
        chk_a("ldm2_not", 1'b1, 3'b100, 3'd4, 16'h0, 8'd5, 8'd6, 1'b0);
        step();
        chk_a("ldm2_hlt", 1'b1, 3'b111, 3'd0, 16'h0, 8'd6, 8'd6, 1'b1);

        // Reset while in FETCH_IMM, asserted mid-cycle
        reset_a();
        step();
        step();
        step();
        step();
        chk_a("pre_mid_rst", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd4, 1'b0);
        #3;
        rst_a = 1'b0;
        #1;
        chk_a("mid_rst", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd0, 1'b0);
        step();
        rst_a = 1'b1;
        step();
        chk_a("restart_bubble", 1'b0, 3'd0, 3'd0, 16'h0, 8'd0, 8'd1, 1'b0);
        step();
        chk_a("restart_ldm", 1'b1, 3'b001, 3'd1, 16'hBEEF, 8'd0, 8'd2, 1'b0);

        // PC wrap on the 4-bit instance
        mem_b[15] = 16'h2400;
        mem_b[0]  = 16'hBEEF;
        mem_b[1]  = 16'h6530;
        #1;
        chk("wrap.rst_addr", 32'(addr_b), 32'd15);
        step();
        rst_b = 1'b1;
        step();
        chk("wrap.bubble_valid", 32'(valid_b), 32'd0);
        chk("wrap.bubble_addr", 32'(addr_b), 32'd0);
        step();
        chk("wrap.ldm_valid", 32'(valid_b), 32'd1);
        chk("wrap.ldm_op", 32'(op_b), 32'd1);
        chk("wrap.ldm_imm", 32'(imm_b), 32'hBEEF);
        chk("wrap.ldm_pc", 32'(ipc_b), 32'd15);
        chk("wrap.next_addr", 32'(addr_b), 32'd1);
        step();
        chk("wrap.add_op", 32'(op_b), 32'd3);
        chk("wrap.add_pc", 32'(ipc_b), 32'd1);
        chk("wrap.halted", 32'(halted_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the pipelined processor. It keeps the program counter, reads the instruction memory, and splits each instruction into fields. Load-immediate is a two-word instruction; this block fetches both words before issuing it. Its registered opcode output drives the 3-bit opcode input of the control unit, and its register fields and immediate feed the decode stage.

## Interface
- ADDR_W, 8: PC and instruction-memory address width.
- INSTR_W, 16: instruction and immediate word width (fixed at 16; field positions below assume it).
- RESET_PC, 0: PC value loaded on reset.

- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- stall  input  1  hazard stall from downstream; while high, all state holds.
- imem_addr  output  ADDR_W  instruction-memory address; always equals pc.
- imem_data  input  INSTR_W  instruction word at imem_addr (asynchronous-read memory, same-cycle data).
- if_id_valid  output  1  IF/ID register holds a real instruction.
- if_id_opcode  output  3  opcode to the control unit; 3'b000 whenever if_id_valid=0.
- if_id_rd, if_id_rs1, if_id_rs2  output  3 each  register fields.
- if_id_imm  output  16  immediate (load-immediate only, else 0).
- if_id_pc  output  ADDR_W  address of the instruction's first word.
- halted  output  1  fetch stopped by HLT.

## Operation
- Instruction word fields: [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
- Opcodes: 001 LDM (two words), 010 STD, 011 ADD, 100 NOT, 111 HLT, 000/101/110 passed through unchanged as single-word instructions (the control unit decodes them as no-ops).
- States: FETCH, FETCH_IMM, HALT.
- FETCH, stall=0:
  - Opcode != 001 and != 111: load the fields into IF/ID, set if_id_valid=1, set if_id_imm=0, set if_id_pc=pc, set pc=pc+1, stay in FETCH.
  - Opcode 001: hold the fields and pc in internal shadow registers, output a bubble (valid=0, opcode=000), set pc=pc+1, go to FETCH_IMM.
  - Opcode 111: issue it as valid with opcode 111, do not increment pc, go to HALT.
- FETCH_IMM, stall=0: set if_id_imm=imem_data, load the shadowed fields into IF/ID with if_id_pc = the shadowed pc and valid=1, set pc=pc+1, go to FETCH.
- HALT: output a bubble every cycle, pc frozen, halted=1. Only rst_n exits this state.
- stall=1 in any state: pc, state, shadow registers and all IF/ID outputs hold their values, including a valid instruction. imem_data is re-sampled after release.
- PC arithmetic is modulo 2^ADDR_W: from 2^ADDR_W-1 the next value is 0. An LDM whose first word is at the top address takes its immediate from address 0.

## Timing
- Reset (asynchronous, immediate): pc=RESET_PC, state=FETCH, if_id_valid=0, all if_id_* = 0, halted=0, shadow registers = 0. The first fetch edge is the first rising clk edge after rst_n deasserts.
- Single-word instruction: one cycle per instruction. The word presented at cycle N is on IF/ID after edge N. The control unit registers its decode one edge later.
- LDM: two cycles. Exactly one bubble precedes the issued LDM.
- HLT: issued on the edge after it is fetched. halted=1 from that same edge.
- Assertion of rst_n mid-LDM (in FETCH_IMM) discards the partial instruction. No half-issued LDM ever appears on the outputs.
- stall is sampled only at rising edges. There is no combinational path from stall to any output.

## Test plan
- Reset then straight-line code: mem[0..2]=ADD r1,r2,r3 (0x6530); NOT r4 (0x9000); STD (0x4000). Required: opcodes 011, 100, 010 on three consecutive cycles, each valid=1, with if_id_pc 0, 1, 2 and if_id_rd=1 on the first.
- LDM: mem[0]=0x2400 (LDM r1), mem[1]=0xBEEF, mem[2]=ADD. Required: cycle 1 is a bubble (opcode 000). Cycle 2 is opcode 001, rd=1, imm=0xBEEF, if_id_pc=0. Cycle 3 is ADD with if_id_pc=2.
- Stall: assert stall for 3 cycles while ADD is on IF/ID, once in FETCH and once in FETCH_IMM. Required: outputs and pc frozen for the whole stall. After release, the sequence resumes with no lost or duplicated instruction.
- HLT: mem[3]=0xE000. Required: opcode 111 issued valid once, then halted=1, continuous bubbles, and imem_addr stuck at 3 for 20 cycles.
- Wrap: ADDR_W=4, RESET_PC=15, LDM at 15, imm at 0. Required: imm taken from mem[0], if_id_pc=15, next fetch at 1.
- Reset mid-LDM: pull rst_n low while in FETCH_IMM. Required: all outputs 0 immediately (before the next edge), and after release fetch restarts at RESET_PC.
